// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, branch flush and vector-op freeze sequencing for a 5-stage pipeline
module pipeline_hazard_controller #(
  parameter int ADDR_W  = 4,
  parameter int VEC_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WA3E,
  input  logic              MemtoRegE,
  input  logic              RegWriteE,
  input  logic              BranchTakenE,
  input  logic              VecStartE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              vec_busy,
  output logic [CNT_W-1:0]  stall_cycles
);
  localparam int VW = $clog2(VEC_LAT) + 1;
  typedef enum logic {RUN, VEC_WAIT} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic in_run, load_use, br, vs, lu;
  // Priority resolution in RUN: branch > vector start > load-use. The start cycle
  // plus VEC_LAT-2 wait cycles gives a total freeze of VEC_LAT-1 cycles, so the
  // wait ends on the cycle where the counter is about to reach zero.
  always_comb begin
    in_run    = state_q == RUN;
    load_use  = MemtoRegE & RegWriteE & (WA3E != '0) & ((WA3E == RA1D) | (WA3E == RA2D));
    br        = in_run & BranchTakenE;
    vs        = in_run & ~BranchTakenE & VecStartE & (VEC_LAT > 1);
    lu        = in_run & ~BranchTakenE & ~vs & load_use;
    StallF    = ~rst & (~in_run | vs | lu);
    StallD    = StallF;
    StallE    = ~rst & (~in_run | vs);
    FlushD    = ~rst & br;
    FlushE    = ~rst & (br | lu);
    vec_busy  = state_q == VEC_WAIT;
    state_d   = in_run ? (vs ? VEC_WAIT : RUN) : (vec_cnt_q <= VW'(1) ? RUN : VEC_WAIT);
    vec_cnt_d = vs ? VW'(VEC_LAT - 2) : in_run ? vec_cnt_q : (vec_cnt_q == '0 ? '0 : vec_cnt_q - VW'(1));
    stall_d   = (StallF & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    stall_cycles = stall_q;
  end
  // State, vector countdown and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      vec_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      stall_q   <= stall_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed stimulus checked against a cycle-level behavioural model
module tb_pipeline_hazard_controller;
  localparam int VEC_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1;
  logic [3:0] RA1D = 0, RA2D = 0, WA3E = 0;
  logic MemtoRegE = 0, RegWriteE = 0, BranchTakenE = 0, VecStartE = 0;
  logic StallF, StallD, StallE, FlushD, FlushE, vec_busy;
  logic [CNT_W-1:0] stall_cycles;
  int checks = 0, passes = 0;
  logic en = 0;
  int rem = 0, stalls = 0, rem_n = 0, stalls_n = 0;

  pipeline_hazard_controller #(.ADDR_W(4), .VEC_LAT(VEC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .BranchTakenE(BranchTakenE),
    .VecStartE(VecStartE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .vec_busy(vec_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  // Model: rem = remaining frozen wait cycles after the start cycle, stalls = saturating count
  always @(negedge clk) if (en) begin
    logic sf, sd, se, fd, fe, busy, hz;
    {sf, sd, se, fd, fe} = '0;
    busy = rem > 0;
    hz = MemtoRegE && RegWriteE && WA3E != 0 && (WA3E == RA1D || WA3E == RA2D);
    rem_n = 0;
    if (rst) begin
    end else if (rem > 0) begin
      {sf, sd, se} = 3'b111;
      rem_n = rem - 1;
    end else if (BranchTakenE) begin
      {fd, fe} = 2'b11;
    end else if (VecStartE) begin
      {sf, sd, se} = 3'b111;
      rem_n = VEC_LAT - 2;
    end else if (hz) begin
      {sf, sd, fe} = 3'b111;
    end
    stalls_n = rst ? 0 : (stalls + int'(sf) > CMAX ? CMAX : stalls + int'(sf));
    chk("StallF", 32'(StallF), 32'(sf));
    chk("StallD", 32'(StallD), 32'(sd));
    chk("StallE", 32'(StallE), 32'(se));
    chk("FlushD", 32'(FlushD), 32'(fd));
    chk("FlushE", 32'(FlushE), 32'(fe));
    chk("vec_busy", 32'(vec_busy), 32'(busy));
    chk("stall_cycles", 32'(stall_cycles), 32'(stalls));
  end

  always @(posedge clk) begin
    if (rst) begin
      en <= 1;
      rem <= 0;
      stalls <= 0;
    end else if (en) begin
      rem <= rem_n;
      stalls <= stalls_n;
    end
  end

  task automatic cyc(input logic [3:0] a1, a2, w, input logic m, r, b, v);
    {RA1D, RA2D, WA3E, MemtoRegE, RegWriteE, BranchTakenE, VecStartE} = {a1, a2, w, m, r, b, v};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    rst = 0;
  endtask

  initial begin
    // T1: reset with random inputs
    rst = 1;
    for (int i = 0; i < 2; i++)
      cyc(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    rst = 0;
    idle();
    chk("t1_stall_cycles", 32'(stall_cycles), 0);
    chk("t1_vec_busy", 32'(vec_busy), 0);
    chk("t1_StallF", 32'(StallF), 0);
    // T2: load-use on RA1D, then RA2D, then WA3E=0 never hazards
    cyc(5, 0, 5, 1, 1, 0, 0);
    idle();
    chk("t2_count1", 32'(stall_cycles), 1);
    chk("t2_StallF_cleared", 32'(StallF), 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(3, 7, 7, 1, 1, 0, 0);
    cyc(7, 3, 7, 1, 0, 0, 0);
    cyc(7, 3, 7, 0, 1, 0, 0);
    idle();
    chk("t2_count2", 32'(stall_cycles), 2);
    // T3: branch beats vector start
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t3_vec_busy", 32'(vec_busy), 0);
    chk("t3_count", 32'(stall_cycles), 0);
    cyc(5, 0, 5, 1, 1, 1, 0);
    idle();
    chk("t3_branch_over_loaduse", 32'(stall_cycles), 0);
    // T4: vector op, branch and load-use inside window are ignored
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t4_busy1", 32'(vec_busy), 1);
    cyc(5, 0, 5, 1, 1, 1, 1);
    chk("t4_busy2", 32'(vec_busy), 1);
    idle();
    chk("t4_busy_end", 32'(vec_busy), 0);
    chk("t4_count", 32'(stall_cycles), 3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("t4_count_again", 32'(stall_cycles), 6);
    // T5: reset during second stall cycle
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    rst = 1;
    idle();
    rst = 0;
    chk("t5_vec_busy", 32'(vec_busy), 0);
    chk("t5_StallF", 32'(StallF), 0);
    chk("t5_StallE", 32'(StallE), 0);
    idle();
    // T6: saturation
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 9, 9, 1, 1, 0, 0);
    chk("t6_saturated", 32'(stall_cycles), 15);
    idle();
    idle();
    chk("t6_no_wrap", 32'(stall_cycles), 15);
    do_reset();
    idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
